fx_out_i2s_tx: RTL and testbench
================================

// Module: fx_out_i2s_tx
// PURPOSE
//  Output stage after the last effect in the FX chain (delay, FX 6). Consumes stereo samples from the chain
//  through a valid/ready handshake. Serialises them as a standard I2S master stream: BCLK, LRCLK and SDATA,
//  MSB first, one-BCLK data delay after the LRCLK edge. Feeds the board audio DAC.
//  A one-frame holding buffer decouples the chain from the serial frame timing.
// PARAMETERS
//  DATA_W   16  bits per channel sample; one I2S slot is DATA_W BCLKs, one frame is 2*DATA_W BCLKs (>=2)
//  CLK_DIV  4   clk cycles per BCLK half-period (>=1); BCLK period = 2*CLK_DIV clk
// PORTS
//  clk         in   1             system clock; all logic on rising edge
//  reset       in   1             asynchronous, active-high reset
//  enable      in   1             1 = run serial clocks; 0 = idle serial side
//  audio_in    in   [1:0][DATA_W] stereo sample, [0]=left, [1]=right, two's complement
//  in_valid    in   1             audio_in valid
//  in_ready    out  1             holding buffer can accept; transfer when in_valid & in_ready
//  i2s_bclk    out  1             bit clock, registered
//  i2s_lrclk   out  1             word select, 0=left 1=right, registered
//  i2s_sdata   out  1             serial data, changes only on BCLK falling edge, registered
//  underrun    out  1             1-clk pulse when a frame starts with an empty holding buffer
// BEHAVIOUR
//  Reset (async, immediate): bclk=lrclk=sdata=0, underrun=0, hold_valid=0 (so in_ready=1), div_cnt=0,
//   bit_cnt=2*DATA_W-1, shift register=0.
//  in_ready = !hold_valid (combinational). Accept -> hold <= audio_in, hold_valid <= 1.
//  Divider: when enable, div_cnt counts 0..CLK_DIV-1; at CLK_DIV-1 it wraps and bclk toggles.
//  Shift event = cycle where bclk toggles 1->0. On each shift event bit_cnt advances mod 2*DATA_W to slot k.
//  Frame load (shift event with k==0):
//   - hold_valid=1: sr <= {hold[0],hold[1]} (left in upper half), hold_valid <= 0.
//   - hold_valid=0: sr <= 0; underrun pulses 1 clk.
//  In the same shift event, sdata <= sr bit for slot k (slot 0 = left MSB .. DATA_W-1 = left LSB;
//   DATA_W = right MSB .. 2*DATA_W-1 = right LSB). On load, sdata takes the MSB of the newly loaded value.
//  lrclk <= 1 for k in [DATA_W-1, 2*DATA_W-2], else 0. LRCLK therefore leads the data by one BCLK
//   (standard I2S).
//  Start from idle: the first toggle is a rising edge. The first falling edge (2*CLK_DIV clk after enable)
//   is the k=0 load.
//  Latency: a sample accepted at least 1 clk before a frame load has its left MSB on sdata at that load;
//   max wait is one frame (4*DATA_W*CLK_DIV clk).
//  Load and accept in the same cycle with hold empty: the load sees the buffer empty (zeros, underrun).
//   The sample is captured into hold for the next frame.
//  in_ready cannot be 1 while hold is full, so a sample is never overwritten or dropped.
//  enable=0 (anytime, incl. mid-frame): next clk bclk=lrclk=sdata=0 and div_cnt/bit_cnt return to idle values;
//   the partial frame is abandoned. hold and hold_valid are retained and the handshake still works.
//   underrun does not pulse while disabled.
//  Reset mid-frame: immediate return to reset values; the held sample is discarded.
//  No arithmetic on sample data: bits pass through unchanged; sign is not extended or truncated.
// TESTING (DATA_W=16, CLK_DIV=2: BCLK = 4 clk, frame = 128 clk)
//  1 Assert reset with clk stopped -> bclk/lrclk/sdata/underrun=0 at once; after release in_ready=1.
//  2 enable=1, one transfer L=16'hA5F0 R=16'h0F0F -> sampled on BCLK rising edges, frame 1 sdata reads
//    A5F0 then 0F0F MSB first; lrclk=0 during slots 0-14 and 31, 1 during slots 15-30; no underrun.
//  3 enable=1, never assert in_valid -> sdata stays 0; underrun pulses exactly 1 clk every 128 clk.
//  4 Hold in_valid with 3 samples (1111/2222, 3333/4444, 5555/6666) -> in_ready falls after each accept
//    and re-rises 1 clk after each load; 3 consecutive frames carry the samples in order with no underrun.
//  5 Drop enable at slot 10 of a frame holding a queued sample -> bclk/lrclk/sdata=0 next clk and
//    in_ready stays 0. Re-enable -> the queued sample goes out intact in the first full frame.
//  6 Pulse reset mid-frame with hold full -> outputs 0 without a clk edge, in_ready=1 after release.
//    On re-enable the first frame is zeros with an underrun pulse.

Source files
------------

// File: rtl/fx_out_i2s_tx_if.sv
// Stereo sample handshake from the last FX stage into the I2S output stage.
// audio_in[0] is left, audio_in[1] is right, two's complement, DATA_W bits each.
// Transfer happens on any clock where in_valid and in_ready are both high.
interface fx_out_i2s_tx_if #(
  parameter int DATA_W = 16
);
  logic [1:0][DATA_W-1:0] audio_in;
  logic                   in_valid;
  logic                   in_ready;

  modport master (output audio_in, output in_valid, input in_ready);
  modport slave  (input audio_in, input in_valid, output in_ready);
endinterface

// File: rtl/fx_out_i2s_tx.sv
// I2S master transmitter: one-frame holding buffer feeding a BCLK/LRCLK/SDATA serialiser.
// Latency: a sample held at least 1 clk before a frame load has its left MSB on sdata at that load.
// Backpressure: in_ready = !hold_valid; the buffer frees only when a frame load consumes it.
module fx_out_i2s_tx #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  fx_out_i2s_tx_if.slave       in_if,
  output logic                 i2s_bclk,
  output logic                 i2s_lrclk,
  output logic                 i2s_sdata,
  output logic                 underrun
);

  localparam int FRAME_W = 2 * DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(FRAME_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]             div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]             bit_cnt_q, bit_cnt_d;
  logic                         bclk_q, bclk_d;
  logic                         lrclk_q, lrclk_d;
  logic                         sdata_q, sdata_d;
  logic                         underrun_q, underrun_d;
  logic [FRAME_W-1:0]           sr_q, sr_d;
  logic [1:0][DATA_W-1:0]       hold_q, hold_d;
  logic                         hold_valid_q, hold_valid_d;
  logic [CNT_W-1:0]             slot;
  logic                         accept;

  assign in_if.in_ready = !hold_valid_q;
  assign accept         = in_if.in_valid && !hold_valid_q;

  assign i2s_bclk  = bclk_q;
  assign i2s_lrclk = lrclk_q;
  assign i2s_sdata = sdata_q;
  assign underrun  = underrun_q;

  // Next state: buffer capture, BCLK divider and per-falling-edge slot/serial update.
  always_comb begin
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    bclk_d       = bclk_q;
    lrclk_d      = lrclk_q;
    sdata_d      = sdata_q;
    underrun_d   = 1'b0;
    sr_d         = sr_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    slot         = bit_cnt_q;

    // The handshake keeps working whether or not the serial side runs.
    if (accept) begin
      hold_d       = in_if.audio_in;
      hold_valid_d = 1'b1;
    end

    if (!enable) begin
      // Abandon any partial frame; the next enable starts with a rising BCLK.
      div_cnt_d = '0;
      bit_cnt_d = LAST_SLOT;
      bclk_d    = 1'b0;
      lrclk_d   = 1'b0;
      sdata_d   = 1'b0;
    end else if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      bclk_d    = !bclk_q;
      // BCLK falling edge: advance to the next slot and drive its bit.
      if (bclk_q) begin
        slot      = (bit_cnt_q == LAST_SLOT) ? '0 : bit_cnt_q + 1'b1;
        bit_cnt_d = slot;
        if (slot == '0) begin
          // Frame load. A sample accepted on this same clk is not yet visible
          // here, so it waits in hold for the following frame.
          if (hold_valid_q) begin
            sr_d         = {hold_q[0], hold_q[1]};
            hold_valid_d = 1'b0;
          end else begin
            sr_d       = '0;
            underrun_d = 1'b1;
          end
        end
        sdata_d = sr_d[LAST_SLOT - slot];
        // Word select switches one slot before the channel's MSB.
        lrclk_d = (slot >= CNT_W'(DATA_W - 1)) && (slot <= CNT_W'(FRAME_W - 2));
      end
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  // State registers with immediate return to idle on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q    <= '0;
      bit_cnt_q    <= LAST_SLOT;
      bclk_q       <= 1'b0;
      lrclk_q      <= 1'b0;
      sdata_q      <= 1'b0;
      underrun_q   <= 1'b0;
      sr_q         <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      bclk_q       <= bclk_d;
      lrclk_q      <= lrclk_d;
      sdata_q      <= sdata_d;
      underrun_q   <= underrun_d;
      sr_q         <= sr_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

endmodule

// File: tb/tb_fx_out_i2s_tx.sv
// Directed bench for fx_out_i2s_tx with DATA_W=16, CLK_DIV=2 (BCLK = 4 clk, frame = 128 clk).
// A receiver samples sdata/lrclk on BCLK rising edges and collects whole frames.
// Sample vectors come from a table; corner cases are hand-written sequences.
module tb_fx_out_i2s_tx;

  localparam int DATA_W  = 16;
  localparam int CLK_DIV = 2;
  localparam logic [31:0] EXP_LR = 32'h0001_FFFE;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic i2s_bclk, i2s_lrclk, i2s_sdata, underrun;

  fx_out_i2s_tx_if #(.DATA_W(DATA_W)) in_if ();

  fx_out_i2s_tx #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .in_if     (in_if),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrclk (i2s_lrclk),
    .i2s_sdata (i2s_sdata),
    .underrun  (underrun)
  );

  always #5 if (clk_run) clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  // Receiver: rx_nxt is the slot the next BCLK rise samples (-1 = discard).
  int          rx_nxt = -1;
  int          rx_last = -1;
  logic        bclk_prev = 1'b0;
  logic [31:0] rx_dat, rx_lr;
  logic [31:0] frm_dat[$];
  logic [31:0] frm_lr[$];
  int          ur_times[$];

  always @(negedge clk) begin
    if (reset || !enable) begin
      rx_nxt  = -1;
      rx_last = -1;
    end else if (i2s_bclk && !bclk_prev) begin
      if (rx_nxt >= 0) begin
        rx_dat[31-rx_nxt] = i2s_sdata;
        rx_lr[31-rx_nxt]  = i2s_lrclk;
        rx_last = rx_nxt;
        if (rx_nxt == 31) begin
          frm_dat.push_back(rx_dat);
          frm_lr.push_back(rx_lr);
        end
      end
      rx_nxt = (rx_nxt == 31) ? 0 : rx_nxt + 1;
    end
    bclk_prev = i2s_bclk;
    if (underrun === 1'b1) ur_times.push_back(cyc);
  end

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_rx();
    frm_dat.delete();
    frm_lr.delete();
    ur_times.delete();
  endtask

  // Offer one sample and hold it until it transfers; in_ready must drop afterwards.
  task automatic push(input logic [15:0] l, input logic [15:0] r, input string nm);
    int n = 0;
    in_if.audio_in[0] = l;
    in_if.audio_in[1] = r;
    in_if.in_valid    = 1'b1;
    while (!in_if.in_ready && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, "_accept_timeout"}, 32'(n >= 600), 32'd0);
    @(posedge clk); #1;
    in_if.in_valid = 1'b0;
    check({nm, "_ready_low"}, 32'(in_if.in_ready), 32'd0);
  endtask

  task automatic wait_frames(input int n, input string nm);
    int t = 0;
    while (frm_dat.size() < n && t < 2000) begin
      @(negedge clk); #1;
      t++;
    end
    check({nm, "_frame_timeout"}, 32'(frm_dat.size() < n), 32'd0);
  endtask

  task automatic check_frame(input int idx, input logic [31:0] exp, input string nm);
    logic [31:0] d, lr;
    d  = (idx < frm_dat.size()) ? frm_dat[idx] : 32'hxxxx_xxxx;
    lr = (idx < frm_lr.size())  ? frm_lr[idx]  : 32'hxxxx_xxxx;
    check({nm, "_sdata"}, d, exp);
    check({nm, "_lrclk"}, lr, EXP_LR);
  endtask

  initial begin
    int t;
    int d0, d1;

    vecs[0] = '{16'hA5F0, 16'h0F0F, 32'hA5F0_0F0F};
    vecs[1] = '{16'h1111, 16'h2222, 32'h1111_2222};
    vecs[2] = '{16'h3333, 16'h4444, 32'h3333_4444};
    vecs[3] = '{16'h5555, 16'h6666, 32'h5555_6666};
    vecs[4] = '{16'h8001, 16'h7FFE, 32'h8001_7FFE};

    in_if.audio_in = '0;
    in_if.in_valid = 1'b0;

    // 1: reset with the clock stopped
    #2 reset = 1'b1;
    #1;
    check("t1_bclk", 32'(i2s_bclk), 32'd0);
    check("t1_lrclk", 32'(i2s_lrclk), 32'd0);
    check("t1_sdata", 32'(i2s_sdata), 32'd0);
    check("t1_underrun", 32'(underrun), 32'd0);
    #5 reset = 1'b0;
    clk_run = 1'b1;
    @(posedge clk); #1;
    check("t1_in_ready", 32'(in_if.in_ready), 32'd1);

    // 2: one sample queued while idle, then enable
    push(vecs[0].l, vecs[0].r, "t2");
    clear_rx();
    enable = 1'b1;
    wait_frames(1, "t2");
    check_frame(0, vecs[0].exp_dat, "t2_f0");
    check("t2_no_underrun", 32'(ur_times.size()), 32'd0);

    // 3: starved stream: zeros, one underrun pulse per 128 clk
    clear_rx();
    wait_frames(3, "t3");
    for (int i = 0; i < 3; i++) check_frame(i, 32'h0, $sformatf("t3_f%0d", i));
    check("t3_underrun_count", 32'(ur_times.size()), 32'd3);
    d0 = (ur_times.size() >= 3) ? ur_times[1] - ur_times[0] : -1;
    d1 = (ur_times.size() >= 3) ? ur_times[2] - ur_times[1] : -1;
    check("t3_underrun_period0", 32'(d0), 32'd128);
    check("t3_underrun_period1", 32'(d1), 32'd128);

    // 4: back-to-back samples from the table, streamed without gaps
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clear_rx();
    push(vecs[1].l, vecs[1].r, "t4_v1");
    enable = 1'b1;
    for (int i = 2; i < 5; i++) push(vecs[i].l, vecs[i].r, $sformatf("t4_v%0d", i));
    wait_frames(4, "t4");
    for (int i = 0; i < 4; i++) check_frame(i, vecs[i+1].exp_dat, $sformatf("t4_f%0d", i));
    check("t4_no_underrun", 32'(ur_times.size()), 32'd0);

    // 5: disable at slot 10 with a sample queued, then resume
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clear_rx();
    push(16'hFFFF, 16'hFFFF, "t5_a");
    enable = 1'b1;
    push(16'h9ABC, 16'hDEF0, "t5_b");
    t = 0;
    while (rx_last != 10 && t < 2000) begin
      @(negedge clk); #1;
      t++;
    end
    check("t5_slot10_timeout", 32'(t >= 2000), 32'd0);
    check("t5_sdata_before", 32'(i2s_sdata), 32'd1);
    check("t5_bclk_before", 32'(i2s_bclk), 32'd1);
    enable = 1'b0;
    @(posedge clk); #1;
    check("t5_bclk_off", 32'(i2s_bclk), 32'd0);
    check("t5_lrclk_off", 32'(i2s_lrclk), 32'd0);
    check("t5_sdata_off", 32'(i2s_sdata), 32'd0);
    check("t5_ready_off", 32'(in_if.in_ready), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("t5_ready_held", 32'(in_if.in_ready), 32'd0);
    clear_rx();
    enable = 1'b1;
    wait_frames(1, "t5");
    check_frame(0, 32'h9ABC_DEF0, "t5_f0");
    check("t5_no_underrun", 32'(ur_times.size()), 32'd0);

    // 6: reset pulse mid-frame with the buffer full
    repeat (10) @(posedge clk);
    #1;
    push(16'h5A5A, 16'hC3C3, "t6");
    repeat (20) @(posedge clk);
    t = 0;
    @(negedge clk);
    while (!i2s_bclk && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("t6_bclk_high_before", 32'(i2s_bclk), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("t6_bclk", 32'(i2s_bclk), 32'd0);
    check("t6_lrclk", 32'(i2s_lrclk), 32'd0);
    check("t6_sdata", 32'(i2s_sdata), 32'd0);
    check("t6_underrun", 32'(underrun), 32'd0);
    enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("t6_in_ready", 32'(in_if.in_ready), 32'd1);
    clear_rx();
    enable = 1'b1;
    wait_frames(1, "t6");
    check_frame(0, 32'h0, "t6_f0");
    check("t6_underrun_count", 32'(ur_times.size()), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
